// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply front end: op codes, FSM
// states and timeout counter width.
package hilo_pkg;

    localparam int OP_W      = 3;
    localparam int TIMEOUT_W = 6;

    // 3'b111 is left unnamed on purpose; it decodes as a NOP.
    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_MFHI  = 3'd3,
        OP_MFLO  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } opE;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_GO   = 3'd2,
        S_WAIT = 3'd3,
        S_FIX  = 3'd4
    } stateE;

endpackage

// File: rtl/hilo_mul_ctrl_if.sv
// Execute-stage request bus into the HI/LO multiply front end.
// master = execute stage, slave = hilo_mul_ctrl.
interface hilo_mul_ctrl_if;
    import hilo_pkg::*;

    logic            iValid;
    logic [OP_W-1:0] iOp;
    logic [31:0]     iRs;
    logic [31:0]     iRt;
    logic            oStall;
    logic [31:0]     oRdata;

    modport master (output iValid, iOp, iRs, iRt, input oStall, oRdata);
    modport slave  (input iValid, iOp, iRs, iRt, output oStall, oRdata);

endinterface

// File: rtl/hilo_fix.sv
// Turns the signed high word from the core into the unsigned high word:
// each operand with its top bit set contributes 2^32 * other operand.
module hilo_fix (
    input  logic [31:0] hi_s,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] hi_u
);

    // Modulo-2^32 sum of the signed high word and both correction terms.
    always_comb begin
        hi_u = hi_s + (rs[31] ? rt : 32'd0) + (rt[31] ? rs : 32'd0);
    end

endmodule

// File: rtl/hilo_mul_ctrl.sv
// HI/LO front end for the iterative Booth multiplier core.
// Build option: define HILO_MULTU_EN to give MULTU the unsigned high-word
// correction; without it MULTU runs exactly as a signed MULT.
//
// state | meaning
// IDLE  | accepting ops; MF/MT served here
// ARM   | core held in reset for one cycle to clear its sticky done
// GO    | one-cycle start pulse to the core
// WAIT  | waiting for done, bounded by TIMEOUT_CYC
// FIX   | HI/LO written from the core product at the end of this cycle
module hilo_mul_ctrl
    import hilo_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 63
) (
    input  logic              iClk,
    input  logic              iReset,
    hilo_mul_ctrl_if.slave    bus,
    output logic              oBusy,
    output logic              oTimeout,
    output logic              oMulRst_b,
    output logic              oMulGo,
    output logic [31:0]       oMer,
    output logic [31:0]       oMand,
    input  logic              iMulDone,
    input  logic [31:0]       iMulHi,
    input  logic [31:0]       iMulLo
);

    localparam logic [TIMEOUT_W-1:0] TMO = TIMEOUT_CYC[TIMEOUT_W-1:0];

    stateE                state;
    stateE                stateNext;
    logic [TIMEOUT_W-1:0] waitCnt;
    logic [TIMEOUT_W-1:0] cntInc;
    logic [31:0]          hi;
    logic [31:0]          lo;
    logic [31:0]          hiResult;
    logic                 accept;
    logic                 mulAccept;
    logic                 timeoutHit;

    // Request decode, next state and core handshake outputs.
    always_comb begin
        stateNext  = state;
        cntInc     = waitCnt + 1'b1;
        accept     = bus.iValid && (state == S_IDLE);
        mulAccept  = accept && ((bus.iOp == OP_MULT) || (bus.iOp == OP_MULTU));
        timeoutHit = (state == S_WAIT) && !iMulDone && (cntInc == TMO);
        case (state)
            S_IDLE: if (mulAccept) stateNext = S_ARM;
            S_ARM:  stateNext = S_GO;
            S_GO:   stateNext = S_WAIT;
            S_WAIT: begin
                if (iMulDone)        stateNext = S_FIX;
                else if (timeoutHit) stateNext = S_IDLE;
            end
            S_FIX:  stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    assign bus.oStall = bus.iValid && (bus.iOp != OP_NOP) && (bus.iOp != 3'b111)
                        && (state != S_IDLE);
    assign bus.oRdata = (accept && (bus.iOp == OP_MFHI)) ? hi :
                        (accept && (bus.iOp == OP_MFLO)) ? lo : 32'd0;
    assign oBusy      = (state != S_IDLE);
    assign oTimeout   = timeoutHit && !iReset;
    assign oMulGo     = (state == S_GO) && !iReset;
    assign oMulRst_b  = !iReset && (state != S_ARM);

`ifdef HILO_MULTU_EN
    logic        isUnsigned;
    logic [31:0] hiU;

    hilo_fix uFix (
        .hi_s (iMulHi),
        .rs   (oMand),
        .rt   (oMer),
        .hi_u (hiU)
    );

    // Remember whether the in-flight multiply needs the unsigned fix.
    always_ff @(posedge iClk) begin
        if (iReset)         isUnsigned <= 1'b0;
        else if (mulAccept) isUnsigned <= (bus.iOp == OP_MULTU);
    end

    assign hiResult = isUnsigned ? hiU : iMulHi;
`else
    assign hiResult = iMulHi;
`endif

    // State, wait counter, operand latches and the HI/LO registers.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state   <= S_IDLE;
            waitCnt <= '0;
            hi      <= '0;
            lo      <= '0;
            oMer    <= '0;
            oMand   <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= (state == S_WAIT) ? cntInc : '0;
            if (mulAccept) begin
                oMand <= bus.iRs;
                oMer  <= bus.iRt;
            end
            if (state == S_FIX) begin
                hi <= hiResult;
                lo <= iMulLo;
            end else if (accept && (bus.iOp == OP_MTHI)) begin
                hi <= bus.iRs;
            end else if (accept && (bus.iOp == OP_MTLO)) begin
                lo <= bus.iRs;
            end
        end
    end

endmodule
